bip_uart_debug_unit: RTL and testbench
======================================

# bip_uart_debug_unit

Command/response bridge between the UART (RX/TX byte interfaces) and the BIP CPU core inside the top level. It decodes single-byte commands received from the host, gates the CPU run enable (run-to-halt, single step, CPU reset), snapshots the accumulator and PC, and streams them back to the host over UART TX.

## Interface

- DATA_WIDTH, 16, accumulator width; must be 16 for the byte stream below
- UART_DATA_SIZE, 8, UART byte width
- PC_WIDTH, 11, CPU program-counter width (≤16, zero-extended on send)

- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_rx_data  in  UART_DATA_SIZE  received byte, valid with i_rx_done
- i_rx_done  in  1  one-cycle pulse from UART RX
- o_tx_data  out  UART_DATA_SIZE  byte to transmit, held until i_tx_done
- o_tx_start  out  1  one-cycle pulse launching a TX byte
- i_tx_done  in  1  one-cycle pulse, TX byte finished
- o_bip_enable  out  1  CPU clock enable
- o_bip_rst  out  1  active-high one-cycle CPU reset pulse
- i_bip_halt  in  1  CPU has decoded HALT (level)
- i_acc  in  DATA_WIDTH  CPU accumulator
- i_pc  in  PC_WIDTH  CPU program counter
- o_busy  out  1  high in every state except IDLE

## Operation

- States: IDLE, RUN, STEP, SNAP, SEND, WAIT_TX, ACK.
- IDLE: on i_rx_done decode i_rx_data:
  - 0x53 'S': if i_bip_halt=1 → SNAP (enable never asserted); else → RUN.
  - 0x50 'P': → STEP.
  - 0x52 'R': pulse o_bip_rst, clear cycle counter (if built), → ACK.
  - any other byte: ignored, stay IDLE, no output activity.
- RUN: o_bip_enable=1 each cycle; when i_bip_halt seen high → SNAP.
- STEP: o_bip_enable=1 for exactly one cycle, → SNAP.
- SNAP: register i_acc, i_pc (zero-extended to 16) into snapshot; byte index=0; → SEND.
- SEND: drive o_tx_data = snapshot byte[index], pulse o_tx_start, → WAIT_TX.
- WAIT_TX: on i_tx_done, index+1; if index was last → IDLE else → SEND.
- Byte order: ACC[7:0], ACC[15:8], PC[7:0], PC[15:8] (4 bytes; 6 with counter build).
- ACK: send single byte 0x52 via same SEND/WAIT_TX handshake, then IDLE.
- i_rx_done in any state other than IDLE: byte dropped, no queuing.
- i_tx_done outside WAIT_TX: ignored.

## Timing

- Reset (i_rst=0 at edge): state IDLE; o_bip_enable=0, o_bip_rst=0, o_tx_start=0, o_tx_data=0x00, o_busy=0, snapshot=0, counter=0. Reset mid-RUN/SEND drops enable/start at that same edge; partial response abandoned.
- Command byte at edge N (i_rx_done=1) → o_bip_enable=1 from edge N+1 ('S','P'); o_bip_rst=1 for edge N+1 only ('R').
- RUN: halt sampled high at edge M → o_bip_enable=0 from edge M+1; snapshot captured at edge M+1 (SNAP), first o_tx_start at M+2.
- STEP: enable high N+1 only; snapshot at N+2 (post-instruction values); first o_tx_start at N+3.
- o_tx_start high exactly one cycle per byte; o_tx_data stable from start pulse through i_tx_done.
- Next byte's o_tx_start is the cycle after i_tx_done is sampled.

## Configuration

- BIP_CYCLE_COUNT_EN defined: 16-bit counter increments every cycle o_bip_enable=1, saturates at 0xFFFF, cleared by reset and 'R'; response appends CNT[7:0], CNT[15:8] (6 bytes total).
- Undefined: no counter logic; response is 4 bytes.

## Test plan

- 'S' (0x53), halt asserted after 10 enabled cycles, acc=0x1234, pc=0x00A → enable high 10 cycles, TX 0x34,0x12,0x0A,0x00, then o_busy=0.
- 'P' (0x50), acc=0x00FF, pc=0x003 after step → enable high exactly 1 cycle, TX 0xFF,0x00,0x03,0x00.
- Byte 0x48 in IDLE → no enable, no o_tx_start, o_bip_rst=0, o_busy stays 0.
- 'R' (0x52) → o_bip_rst one-cycle pulse, TX single 0x52; second byte 0x53 arriving during ACK dropped.
- i_rst=0 asserted mid-RUN (enable high) → next edge enable=0, tx_start=0, IDLE; subsequent 'P' works normally.
- With BIP_CYCLE_COUNT_EN: 'R' then run of 10 cycles → TX ends 0x0A,0x00; second 10-cycle run without 'R' → 0x14,0x00.

Source files
------------

// File: rtl/bip_uart_debug_unit.sv
// bip_uart_debug_unit: host byte-command bridge to the BIP core (run, single step, reset, snapshot readback).
// Build option BIP_CYCLE_COUNT_EN adds a saturating enabled-cycle counter appended to each snapshot response.
//
// state   | meaning
// IDLE    | waiting for a command byte
// RUN     | core enabled until it reports HALT
// STEP    | core enabled for one cycle
// SNAP    | capture accumulator/PC, start response at byte 0
// SEND    | launch current response byte
// WAIT_TX | wait for UART to finish the byte
// ACK     | pulse core reset, then answer with a single 'R'
module bip_uart_debug_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int UART_DATA_SIZE = 8,
  parameter int PC_WIDTH       = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [UART_DATA_SIZE-1:0] i_rx_data,
  input  logic                      i_rx_done,
  output logic [UART_DATA_SIZE-1:0] o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic                      o_bip_enable,
  output logic                      o_bip_rst,
  input  logic                      i_bip_halt,
  input  logic [DATA_WIDTH-1:0]     i_acc,
  input  logic [PC_WIDTH-1:0]       i_pc,
  output logic                      o_busy
);

  localparam logic [UART_DATA_SIZE-1:0] CMD_RUN  = UART_DATA_SIZE'(8'h53);
  localparam logic [UART_DATA_SIZE-1:0] CMD_STEP = UART_DATA_SIZE'(8'h50);
  localparam logic [UART_DATA_SIZE-1:0] CMD_RST  = UART_DATA_SIZE'(8'h52);

`ifdef BIP_CYCLE_COUNT_EN
  localparam int         RESP_W   = 48;
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam int         RESP_W   = 32;
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_SNAP,
    ST_SEND,
    ST_WAIT_TX,
    ST_ACK
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [15:0]           pc_q;
  logic [RESP_W-1:0]     resp, resp_sh;
  logic [2:0]            last_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      idx_q <= '0;
      ack_q <= 1'b0;
      acc_q <= '0;
      pc_q  <= '0;
    end else begin
      case (state_q)
        ST_SNAP: begin
          acc_q <= i_acc;
          pc_q  <= 16'(i_pc);
          idx_q <= '0;
          ack_q <= 1'b0;
        end
        ST_ACK: begin
          idx_q <= '0;
          ack_q <= 1'b1;
        end
        ST_WAIT_TX: if (i_tx_done) idx_q <= idx_q + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cnt_q;
  logic        rst_cmd;

  assign rst_cmd = (state_q == ST_IDLE) && i_rx_done && (i_rx_data == CMD_RST);

  always_ff @(posedge i_clk) begin
    if (!i_rst)                                  cnt_q <= '0;
    else if (rst_cmd)                            cnt_q <= '0;
    else if (o_bip_enable && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  assign resp = {cnt_q, pc_q, acc_q};
`else
  assign resp = {pc_q, acc_q};
`endif

  // The 'R' acknowledge is a one-byte response sharing the SEND/WAIT_TX handshake.
  assign last_idx = ack_q ? 3'd0 : LAST_IDX;
  assign resp_sh  = resp >> {idx_q, 3'b000};
  assign o_busy   = (state_q != ST_IDLE);
  assign o_tx_data = (state_q == ST_SEND || state_q == ST_WAIT_TX)
                   ? (ack_q ? CMD_RST : resp_sh[UART_DATA_SIZE-1:0])
                   : '0;

  always_comb begin
    state_d      = state_q;
    o_bip_enable = 1'b0;
    o_bip_rst    = 1'b0;
    o_tx_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_RUN:  state_d = i_bip_halt ? ST_SNAP : ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_RST:  state_d = ST_ACK;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        o_bip_enable = 1'b1;
        if (i_bip_halt) state_d = ST_SNAP;
      end
      ST_STEP: begin
        o_bip_enable = 1'b1;
        state_d      = ST_SNAP;
      end
      ST_SNAP: state_d = ST_SEND;
      ST_SEND: begin
        o_tx_start = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) state_d = (idx_q == last_idx) ? ST_IDLE : ST_SEND;
      end
      ST_ACK: begin
        o_bip_rst = 1'b1;
        state_d   = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bip_uart_debug_unit.sv
// Testbench for bip_uart_debug_unit: scenario tasks with randomized run lengths and data,
// checked against a byte-stream model of the command protocol.
module tb_bip_uart_debug_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_bip_enable;
  logic        o_bip_rst;
  logic        i_bip_halt;
  logic [15:0] i_acc;
  logic [10:0] i_pc;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int cnt_m    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         first_gap;
  int         extra_en;
  bit         timeout, unstable, wide_start, late_next;
  logic       busy_after;

  always #5 i_clk = ~i_clk;

  bip_uart_debug_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .i_tx_done    (i_tx_done),
    .o_bip_enable (o_bip_enable),
    .o_bip_rst    (o_bip_rst),
    .i_bip_halt   (i_bip_halt),
    .i_acc        (i_acc),
    .i_pc         (i_pc),
    .o_busy       (o_busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers and reference model ----------------
  task automatic drive_cmd(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic model_count(input int n);
    cnt_m = (cnt_m + n > 65535) ? 65535 : cnt_m + n;
  endtask

  task automatic model_resp(input logic [15:0] acc, input logic [10:0] pc);
    logic [15:0] p;
    logic [15:0] c;
    p = {5'b0, pc};
    c = cnt_m[15:0];
    exp_q.delete();
    exp_q.push_back(acc[7:0]);
    exp_q.push_back(acc[15:8]);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(p[15:8]);
`ifdef BIP_CYCLE_COUNT_EN
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
`endif
  endtask

  // Acts as the UART TX side: accepts bytes with random completion latency.
  task automatic collect(input int nbytes);
    int w;
    logic [7:0] d;
    got_q.delete();
    first_gap = -1; extra_en = 0;
    timeout = 0; unstable = 0; wide_start = 0; late_next = 0;
    for (int b = 0; b < nbytes; b++) begin
      w = 0;
      while (!o_tx_start && w < 200) begin
        @(negedge i_clk);
        w++;
        if (o_bip_enable) extra_en++;
      end
      if (!o_tx_start) begin
        timeout = 1;
        busy_after = o_busy;
        return;
      end
      if (b == 0) first_gap = w;
      else if (w != 0) late_next = 1;
      d = o_tx_data;
      got_q.push_back(d);
      repeat ($urandom_range(0, 3) + 1) begin
        @(negedge i_clk);
        if (o_tx_start) wide_start = 1;
        if (o_tx_data !== d) unstable = 1;
        if (o_bip_enable) extra_en++;
      end
      i_acc = 16'($urandom);
      i_pc  = 11'($urandom_range(0, 2047));
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
    end
    busy_after = o_busy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_bip_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b want=0", o_bip_enable); end
    checks++; if (o_bip_rst !== 1'b0) begin failures++; $display("FAIL reset_bip_rst got=%b want=0", o_bip_rst); end
    checks++; if (o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b want=0", o_tx_start); end
    checks++; if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", o_tx_data); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    i_rst = 1'b1;
    cnt_m = 0;
    @(negedge i_clk);
  endtask

  task automatic test_ignore;
    logic [7:0] b;
    int act;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) b = 8'h48;
      else begin
        b = 8'($urandom);
        while (b == 8'h50 || b == 8'h52 || b == 8'h53) b = 8'($urandom);
      end
      drive_cmd(b);
      act = 0;
      for (int c = 0; c < 8; c++) begin
        if (o_bip_enable || o_tx_start || o_bip_rst || o_busy) act++;
        if (c == 3) i_tx_done = 1'b1;
        else        i_tx_done = 1'b0;
        @(negedge i_clk);
      end
      i_tx_done = 1'b0;
      checks++; if (act != 0) begin failures++; $display("FAIL ignore_byte_%h active_cycles got=%0d want=0", b, act); end
    end
  endtask

  task automatic test_ack_drop;
    int act;
    @(negedge i_clk);
    i_bip_halt = 1'b0;
    i_rx_data = 8'h52;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    checks++; if (o_bip_rst !== 1'b1) begin failures++; $display("FAIL ack_rst_pulse got=%b want=1", o_bip_rst); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL ack_busy got=%b want=1", o_busy); end
    i_rx_data = 8'h53;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    checks++; if (o_bip_rst !== 1'b0) begin failures++; $display("FAIL ack_rst_width got=%b want=0", o_bip_rst); end
    cnt_m = 0;
    exp_q.delete();
    exp_q.push_back(8'h52);
    collect(1);
    checks++; if (timeout) begin failures++; $display("FAIL ack_timeout got=%0d bytes want=1", got_q.size()); end
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL ack_byte got=%p want=%p", got_q, exp_q); end
    checks++; if (first_gap != 0) begin failures++; $display("FAIL ack_start_latency got=%0d want=0", first_gap); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL ack_busy_after got=%b want=0", busy_after); end
    act = 0;
    repeat (10) begin
      if (o_bip_enable || o_tx_start || o_busy) act++;
      @(negedge i_clk);
    end
    checks++; if (act != 0) begin failures++; $display("FAIL ack_dropped_byte active_cycles got=%0d want=0", act); end
  endtask

  task automatic test_run(input int len, input logic [15:0] acc, input logic [10:0] pc);
    int seen, guard;
    i_bip_halt = 1'b0;
    drive_cmd(8'h53);
    checks++; if (o_bip_enable !== 1'b1) begin failures++; $display("FAIL run_enable_first got=%b want=1", o_bip_enable); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%b want=1", o_busy); end
    seen = 0; guard = 0;
    while (guard < len + 50) begin
      if (o_bip_enable) seen++;
      if (seen == len) break;
      @(negedge i_clk);
      guard++;
    end
    checks++; if (seen != len) begin failures++; $display("FAIL run_enable_cycles got=%0d want=%0d", seen, len); end
    i_bip_halt = 1'b1;
    i_acc = acc;
    i_pc = pc;
    model_count(len);
    model_resp(acc, pc);
    collect(exp_q.size());
    i_bip_halt = 1'b0;
    checks++; if (timeout) begin failures++; $display("FAIL run_timeout got=%0d bytes want=%0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL run_byte_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL run_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (first_gap != 2) begin failures++; $display("FAIL run_start_latency got=%0d want=2", first_gap); end
    checks++; if (extra_en != 0) begin failures++; $display("FAIL run_enable_after_halt got=%0d want=0", extra_en); end
    checks++; if (unstable || wide_start || late_next) begin failures++; $display("FAIL run_handshake got=%b%b%b want=000", unstable, wide_start, late_next); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL run_busy_after got=%b want=0", busy_after); end
  endtask

  task automatic test_step(input logic [15:0] acc, input logic [10:0] pc);
    i_bip_halt = 1'b0;
    drive_cmd(8'h50);
    checks++; if (o_bip_enable !== 1'b1) begin failures++; $display("FAIL step_enable got=%b want=1", o_bip_enable); end
    i_acc = acc;
    i_pc = pc;
    model_count(1);
    model_resp(acc, pc);
    collect(exp_q.size());
    checks++; if (timeout) begin failures++; $display("FAIL step_timeout got=%0d bytes want=%0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL step_byte_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL step_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (first_gap != 2) begin failures++; $display("FAIL step_start_latency got=%0d want=2", first_gap); end
    checks++; if (extra_en != 0) begin failures++; $display("FAIL step_enable_width extra=%0d want=0", extra_en); end
    checks++; if (unstable || wide_start || late_next) begin failures++; $display("FAIL step_handshake got=%b%b%b want=000", unstable, wide_start, late_next); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL step_busy_after got=%b want=0", busy_after); end
  endtask

  task automatic test_halted_start(input logic [15:0] acc, input logic [10:0] pc);
    i_bip_halt = 1'b1;
    i_acc = acc;
    i_pc = pc;
    drive_cmd(8'h53);
    checks++; if (o_bip_enable !== 1'b0) begin failures++; $display("FAIL halted_enable got=%b want=0", o_bip_enable); end
    model_resp(acc, pc);
    collect(exp_q.size());
    i_bip_halt = 1'b0;
    checks++; if (timeout || got_q.size() != exp_q.size()) begin failures++; $display("FAIL halted_byte_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL halted_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (first_gap != 1) begin failures++; $display("FAIL halted_start_latency got=%0d want=1", first_gap); end
    checks++; if (extra_en != 0) begin failures++; $display("FAIL halted_enable_seen got=%0d want=0", extra_en); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL halted_busy_after got=%b want=0", busy_after); end
  endtask

  task automatic test_reset_mid_run;
    i_bip_halt = 1'b0;
    drive_cmd(8'h53);
    repeat (3) @(negedge i_clk);
    checks++; if (o_bip_enable !== 1'b1) begin failures++; $display("FAIL midrst_enable_before got=%b want=1", o_bip_enable); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_bip_enable !== 1'b0) begin failures++; $display("FAIL midrst_enable got=%b want=0", o_bip_enable); end
    checks++; if (o_tx_start !== 1'b0) begin failures++; $display("FAIL midrst_tx_start got=%b want=0", o_tx_start); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", o_busy); end
    i_rst = 1'b1;
    cnt_m = 0;
    test_step(16'($urandom), 11'($urandom_range(0, 2047)));
  endtask

  task automatic test_random;
    int op;
    for (int k = 0; k < 12; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0, 1:    test_run($urandom_range(1, 25), 16'($urandom), 11'($urandom_range(0, 2047)));
        2:       test_step(16'($urandom), 11'($urandom_range(0, 2047)));
        default: test_halted_start(16'($urandom), 11'($urandom_range(0, 2047)));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end
  endtask

  initial begin
    i_rst = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    i_bip_halt = 1'b0;
    i_acc = 16'h0000;
    i_pc = 11'h000;
    test_reset;
    test_ignore;
    test_ack_drop;
    test_run(10, 16'h1234, 11'h00A);
    test_run(10, 16'h1234, 11'h00A);
    test_step(16'h00FF, 11'h003);
    test_run(1, 16'hBEEF, 11'h7FF);
    test_halted_start(16'hA5C3, 11'h155);
    test_reset_mid_run;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
